uart_tx_fifo: RTL and testbench

Parametrised successor of the single-word UART transmitter used by the BIP I top level. Adds a write-side FIFO so the interface circuit can queue several bytes without waiting on o_tx_done, configurable word width, 1 or 2 stop bits, and an optional parity bit. Sits between interface_circuit (producer) and the PC receive line, clocked by the shared baud_rate_generator tick.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_tx_fifo.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling default and legal
// frame-format ranges. Used by the tx FIFO transmitter and its rx counterpart.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;
    localparam int WORD_BITS_MIN  = 5;
    localparam int WORD_BITS_MAX  = 9;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO. Registered count drives full/empty, so a
// word pushed into an empty FIFO is poppable only from the following cycle.
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 3
) (
    input  logic                 gclk,
    input  logic                 grst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (ADDR_BITS+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge gclk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write-side FIFO, configurable word width and stop bits.
// Define UART_TX_PARITY_EN to add a parity bit (sense set by PARITY_ODD).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH_WORD_TX  = 8,
    parameter int CANT_BIT_STOP  = 2,
    parameter int FIFO_ADDR_BITS = 3,
    parameter int OVERSAMPLE     = OVERSAMPLE_DEF,
    parameter int PARITY_ODD     = 0
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_rate,
    input  logic [WIDTH_WORD_TX-1:0] i_data_in,
    input  logic                     i_tx_start,
    output logic                     o_bit_tx,
    output logic                     o_tx_done,
    output logic                     o_busy,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow
);

    localparam int IDX_W  = clog2_min1(WIDTH_WORD_TX);
    localparam int TICK_W = clog2_min1(OVERSAMPLE);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(WIDTH_WORD_TX - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(CANT_BIT_STOP - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam bit CFG_OK = (WIDTH_WORD_TX >= WORD_BITS_MIN) && (WIDTH_WORD_TX <= WORD_BITS_MAX)
                         && (CANT_BIT_STOP >= STOP_BITS_MIN) && (CANT_BIT_STOP <= STOP_BITS_MAX)
                         && (PARITY_ODD == 0 || PARITY_ODD == 1) && (OVERSAMPLE >= 1);

    if (!CFG_OK) begin : g_cfg_unsupported
    end

    uart_state_t              state;
    logic [WIDTH_WORD_TX-1:0] shift;
    logic [IDX_W-1:0]         bit_idx;
    logic [TICK_W-1:0]        tick_cnt;
`ifdef UART_TX_PARITY_EN
    logic                     par_bit;
`endif

    logic [WIDTH_WORD_TX-1:0]  fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [FIFO_ADDR_BITS:0]   fifo_count;
    logic                      bit_end;
    logic                      frame_end;
    logic                      pop;

    assign bit_end   = i_rate && (tick_cnt == TICK_LAST);
    assign frame_end = (state == ST_STOP) && bit_end && (bit_idx == STOP_LAST);
    // Pop straight out of the last stop tick so frames run back-to-back.
    assign pop       = (fifo_count != '0) && ((state == ST_IDLE) || frame_end);

    assign o_full  = fifo_full;
    assign o_empty = fifo_empty;

    sync_fifo #(
        .WIDTH     (WIDTH_WORD_TX),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_sync_fifo1 (
        .gclk   (i_clock),
        .grst_n (i_reset),
        .push   (i_tx_start),
        .pop    (pop),
        .din    (i_data_in),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            tick_cnt   <= '0;
            o_bit_tx   <= 1'b1;
            o_busy     <= 1'b0;
            o_tx_done  <= 1'b0;
            o_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            o_tx_done  <= 1'b0;
            o_overflow <= i_tx_start && fifo_full && !pop;

            if (state == ST_IDLE) begin
                o_bit_tx <= 1'b1;
                o_busy   <= 1'b0;
            end else if (i_rate) begin
                if (tick_cnt != TICK_LAST) begin
                    tick_cnt <= tick_cnt + 1'b1;
                end else begin
                    tick_cnt <= '0;
                    case (state)
                        ST_START: begin
                            state    <= ST_DATA;
                            bit_idx  <= '0;
                            o_bit_tx <= shift[0];
                        end
                        ST_DATA: begin
                            if (bit_idx == DATA_LAST) begin
                                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                                state    <= ST_PARITY;
                                o_bit_tx <= par_bit;
`else
                                state    <= ST_STOP;
                                o_bit_tx <= 1'b1;
`endif
                            end else begin
                                bit_idx  <= bit_idx + 1'b1;
                                shift    <= shift >> 1;
                                o_bit_tx <= shift[1];
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        ST_PARITY: begin
                            state    <= ST_STOP;
                            bit_idx  <= '0;
                            o_bit_tx <= 1'b1;
                        end
`endif
                        ST_STOP: begin
                            if (bit_idx == STOP_LAST) begin
                                o_tx_done <= 1'b1;
                                state     <= ST_IDLE;
                                o_busy    <= 1'b0;
                                o_bit_tx  <= 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                        default: begin
                            state    <= ST_IDLE;
                            o_busy   <= 1'b0;
                            o_bit_tx <= 1'b1;
                        end
                    endcase
                end
            end

            // Loading a new word overrides whatever the state logic chose above.
            if (pop) begin
                state    <= ST_START;
                shift    <= fifo_dout;
                bit_idx  <= '0;
                tick_cnt <= '0;
                o_bit_tx <= 1'b0;
                o_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                par_bit  <= (^fifo_dout) ^ 1'(PARITY_ODD);
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a frame-level reference model (word queue,
// frame as a bit list, tick position) predicts every output each cycle.
module tb_uart_tx_fifo;

    localparam int W     = 8;
    localparam int S     = 2;
    localparam int AB    = 3;
    localparam int OS    = 16;
    localparam int PODD  = 0;
    localparam int DEPTH = 1 << AB;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 1 + W + P + S;

    logic         i_clock = 1'b0;
    logic         i_reset = 1'b0;
    logic         i_rate = 1'b0;
    logic [W-1:0] i_data_in = '0;
    logic         i_tx_start = 1'b0;
    logic         o_bit_tx, o_tx_done, o_busy, o_full, o_empty, o_overflow;

    uart_tx_fifo #(
        .WIDTH_WORD_TX (W), .CANT_BIT_STOP (S), .FIFO_ADDR_BITS (AB),
        .OVERSAMPLE (OS), .PARITY_ODD (PODD)
    ) dut (
        .i_clock (i_clock), .i_reset (i_reset), .i_rate (i_rate),
        .i_data_in (i_data_in), .i_tx_start (i_tx_start),
        .o_bit_tx (o_bit_tx), .o_tx_done (o_tx_done), .o_busy (o_busy),
        .o_full (o_full), .o_empty (o_empty), .o_overflow (o_overflow)
    );

    always #5 i_clock = ~i_clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [W-1:0]  mq[$];
    logic [NB-1:0] fb;
    bit            active = 0;
    int            te = 0;
    bit            e_done = 0;
    bit            e_ovf = 0;
    bit            model_en = 0;
    int            sz;
    bit            popped;
    logic [W-1:0]  w;

    function automatic logic [NB-1:0] frame_bits(input logic [W-1:0] d);
        logic [NB-1:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < W; i++) f[1+i] = d[i];
        if (P == 1) f[1+W] = (^d) ^ 1'(PODD);
        return f;
    endfunction

    always @(posedge i_clock) begin
        if (!i_reset) begin
            mq.delete();
            active = 0; te = 0; e_done = 0; e_ovf = 0; model_en = 1;
        end else begin
            sz = mq.size(); popped = 0; e_done = 0; e_ovf = 0;
            if (active && i_rate) begin
                te++;
                if (te == OS*NB) begin active = 0; e_done = 1; end
            end
            if (!active && sz != 0) begin
                w = mq.pop_front();
                fb = frame_bits(w); te = 0; active = 1; popped = 1;
            end
            if (i_tx_start) begin
                if (sz < DEPTH || popped) mq.push_back(i_data_in);
                else e_ovf = 1;
            end
        end
    end

    always @(negedge i_clock) begin
        if (model_en) begin
            check("line",     32'(o_bit_tx),   32'(active ? fb[te/OS] : 1'b1));
            check("busy",     32'(o_busy),     32'(active));
            check("empty",    32'(o_empty),    32'(mq.size() == 0));
            check("full",     32'(o_full),     32'(mq.size() == DEPTH));
            check("tx_done",  32'(o_tx_done),  32'(e_done));
            check("overflow", 32'(o_overflow), 32'(e_ovf));
        end
    end

    task automatic drive(input bit st, input logic [W-1:0] d, input bit r);
        @(negedge i_clock);
        i_tx_start = st; i_data_in = d; i_rate = r;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, r);
    endtask

    initial begin
        logic [W-1:0] words [3];
        words[0] = 8'h55; words[1] = 8'h0F; words[2] = 8'hF0;
        repeat (3) @(negedge i_clock);
        i_reset = 1'b1;
        idle(4, 1'b1);

        // single frame
        drive(1'b1, 8'hA5, 1'b1);
        idle(OS*NB + 20, 1'b1);

        // three back-to-back frames
        for (int i = 0; i < 3; i++) drive(1'b1, words[i], 1'b1);
        idle(3*OS*NB + 20, 1'b1);

        // fill with no ticks until overflow
        for (int i = 0; i < 11; i++) drive(1'b1, W'($urandom), 1'b0);
        idle(3, 1'b0);
        // keep pushing while full and draining: pushes coincide with STOP-end pops
        for (int i = 0; i < 3*OS*NB; i++) drive(1'b1, W'($urandom), 1'b1);
        idle(DEPTH*OS*NB + 40, 1'b1);

        // random traffic with varying tick density
        for (int blk = 0; blk < 12; blk++) begin
            int rp, sp;
            rp = $urandom_range(1, 3);
            sp = $urandom_range(4, 300);
            for (int i = 0; i < 600; i++)
                drive(($urandom % sp) == 0, W'($urandom), ($urandom % rp) == 0);
        end
        idle((DEPTH+1)*OS*NB + 40, 1'b1);

        // reset in the middle of data bit 4 with a second word queued
        drive(1'b1, 8'h3C, 1'b1);
        drive(1'b1, 8'hC3, 1'b1);
        idle(OS*5 + OS/2, 1'b1);
        @(negedge i_clock);
        i_reset = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b1;
        idle(OS*NB + 10, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
